// File: rtl/body_slot_arbiter_if.sv
// Requester/arbiter bundle for body_slot_arbiter: allocate handshake, slot return and pool status.
// master = requesting side, slave = arbiter.
interface body_slot_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int SLOTS = 10,
    parameter int SW    = $clog2(SLOTS)
);
    logic [NREQ-1:0] req;
    logic [NREQ-1:0] gnt;
    logic [SW-1:0]   gnt_slot;
    logic            free_vld;
    logic [SW-1:0]   free_slot;
    logic            free_err;
    logic [SW:0]     used_cnt;
    logic            full;
    logic            empty;
    logic [SW:0]     hwm;

    modport master (
        output req, free_vld, free_slot,
        input  gnt, gnt_slot, free_err, used_cnt, full, empty, hwm
    );

    modport slave (
        input  req, free_vld, free_slot,
        output gnt, gnt_slot, free_err, used_cnt, full, empty, hwm
    );
endinterface

// File: rtl/body_slot_arbiter.sv
// Round-robin allocator for the body buffer slot pool; sole owner of slot occupancy.
// Optional high-water-mark tracking is enabled by defining BODY_SLOT_HWM_EN.
module body_slot_arbiter #(
    parameter int  NREQ  = 4,
    parameter int  SLOTS = 10,
    localparam int SW    = $clog2(SLOTS),
    localparam int RW    = $clog2(NREQ)
) (
    input logic                clock,
    input logic                rst,
    body_slot_arbiter_if.slave bus
);
    typedef enum logic {ARB, HOLD} state_t;

    localparam logic [SW:0] SLOTS_C = (SW+1)'(SLOTS);

    state_t           state;
    logic [SLOTS-1:0] used_map;
    logic [RW-1:0]    rr_ptr;

    logic             req_hit;
    logic [RW-1:0]    win_idx;
    logic             slot_hit;
    logic [SW-1:0]    win_slot;
    logic             do_grant;
    logic             free_ok;
    logic             free_bad;
    logic [SLOTS-1:0] map_next;
    logic [SW:0]      cnt_next;
    logic [RW-1:0]    rr_next;

    // Occupancy count clamped to [0, SLOTS]; a simultaneous grant and free cancel out.
    function automatic logic [SW:0] sat_count(input logic [SW:0] cur, input logic inc, input logic dec);
        logic [SW:0] r;
        r = cur;
        if (inc && !dec && cur < SLOTS_C)
            r = cur + 1'b1;
        else if (dec && !inc && cur != '0)
            r = cur - 1'b1;
        return r;
    endfunction

    // Downward scans so the last hit wins: the nearest requester at/after rr_ptr, the lowest free slot.
    always_comb begin
        req_hit = 1'b0;
        win_idx = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            int idx;
            idx = (int'(rr_ptr) + k) % NREQ;
            if (bus.req[idx]) begin
                req_hit = 1'b1;
                win_idx = RW'(idx);
            end
        end

        slot_hit = 1'b0;
        win_slot = '0;
        for (int s = SLOTS - 1; s >= 0; s--) begin
            if (!used_map[s]) begin
                slot_hit = 1'b1;
                win_slot = SW'(s);
            end
        end
    end

    always_comb begin
        do_grant = (state == ARB) && req_hit && slot_hit && !bus.full;
        free_ok  = bus.free_vld && ({1'b0, bus.free_slot} < SLOTS_C) && used_map[bus.free_slot];
        free_bad = bus.free_vld && !free_ok;
        rr_next  = (win_idx == RW'(NREQ - 1)) ? '0 : win_idx + 1'b1;

        // A freed slot is never the one being granted (that slot is currently free, so its free is illegal).
        map_next = used_map;
        if (free_ok)
            map_next[bus.free_slot] = 1'b0;
        if (do_grant)
            map_next[win_slot] = 1'b1;

        cnt_next = sat_count(bus.used_cnt, do_grant, free_ok);
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state        <= ARB;
            used_map     <= '0;
            rr_ptr       <= '0;
            bus.gnt      <= '0;
            bus.gnt_slot <= '0;
            bus.free_err <= 1'b0;
            bus.used_cnt <= '0;
            bus.full     <= 1'b0;
            bus.empty    <= 1'b1;
        end else begin
            used_map     <= map_next;
            bus.used_cnt <= cnt_next;
            bus.full     <= (cnt_next == SLOTS_C);
            bus.empty    <= (cnt_next == '0);
            bus.free_err <= free_bad;
            case (state)
                ARB: begin
                    if (do_grant) begin
                        bus.gnt      <= NREQ'(1) << win_idx;
                        bus.gnt_slot <= win_slot;
                        rr_ptr       <= rr_next;
                        state        <= HOLD;
                    end else begin
                        bus.gnt <= '0;
                    end
                end
                HOLD: begin
                    bus.gnt <= '0;
                    state   <= ARB;
                end
                default: begin
                    bus.gnt <= '0;
                    state   <= ARB;
                end
            endcase
        end
    end

`ifdef BODY_SLOT_HWM_EN
    always_ff @(posedge clock or posedge rst) begin
        if (rst)
            bus.hwm <= '0;
        else if (cnt_next > bus.hwm)
            bus.hwm <= cnt_next;
    end
`else
    assign bus.hwm = '0;
`endif
endmodule

// File: tb/tb_body_slot_arbiter.sv
// Directed bench for body_slot_arbiter (NREQ=4, SLOTS=10); inputs driven and outputs sampled 1 time unit after each rising edge.
module tb_body_slot_arbiter;
    localparam int NREQ  = 4;
    localparam int SLOTS = 10;
    localparam int SW    = $clog2(SLOTS);

    logic clock;
    logic rst;
    int   checks;
    int   errors;

    body_slot_arbiter_if #(.NREQ(NREQ), .SLOTS(SLOTS)) bus ();

    body_slot_arbiter #(.NREQ(NREQ), .SLOTS(SLOTS)) dut (
        .clock (clock),
        .rst   (rst),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        rst           = 1'b1;
        bus.req       = '0;
        bus.free_vld  = 1'b0;
        bus.free_slot = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (bus.gnt !== 4'b0000) begin errors++; $display("FAIL reset_gnt got %b exp 0000", bus.gnt); end
        checks++; if (bus.gnt_slot !== 4'd0) begin errors++; $display("FAIL reset_gnt_slot got %0d exp 0", bus.gnt_slot); end
        checks++; if (bus.free_err !== 1'b0) begin errors++; $display("FAIL reset_free_err got %b exp 0", bus.free_err); end
        checks++; if (bus.used_cnt !== 5'd0) begin errors++; $display("FAIL reset_used_cnt got %0d exp 0", bus.used_cnt); end
        checks++; if (bus.full !== 1'b0) begin errors++; $display("FAIL reset_full got %b exp 0", bus.full); end
        checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b exp 1", bus.empty); end
        checks++; if (bus.hwm !== 5'd0) begin errors++; $display("FAIL reset_hwm got %0d exp 0", bus.hwm); end
    endtask

    task automatic test_single_grant();
        bus.req = 4'b0001;
        tick();
        checks++; if (bus.gnt !== 4'b0001) begin errors++; $display("FAIL single_gnt got %b exp 0001", bus.gnt); end
        checks++; if (bus.gnt_slot !== 4'd0) begin errors++; $display("FAIL single_slot got %0d exp 0", bus.gnt_slot); end
        bus.req = 4'b0000;
        tick();
        checks++; if (bus.gnt !== 4'b0000) begin errors++; $display("FAIL single_hold_gnt got %b exp 0000", bus.gnt); end
        checks++; if (bus.used_cnt !== 5'd1) begin errors++; $display("FAIL single_used_cnt got %0d exp 1", bus.used_cnt); end
        checks++; if (bus.empty !== 1'b0) begin errors++; $display("FAIL single_empty got %b exp 0", bus.empty); end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_gnt;
        do_reset();
        bus.req = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            exp_gnt = 4'b0001 << k;
            tick();
            checks++; if (bus.gnt !== exp_gnt) begin errors++; $display("FAIL rr_gnt%0d got %b exp %b", k, bus.gnt, exp_gnt); end
            checks++; if (bus.gnt_slot !== 4'(k)) begin errors++; $display("FAIL rr_slot%0d got %0d exp %0d", k, bus.gnt_slot, k); end
            tick();
            checks++; if (bus.gnt !== 4'b0000) begin errors++; $display("FAIL rr_hold%0d got %b exp 0000", k, bus.gnt); end
        end
        bus.req = 4'b0000;
        checks++; if (bus.used_cnt !== 5'd4) begin errors++; $display("FAIL rr_used_cnt got %0d exp 4", bus.used_cnt); end
    endtask

    task automatic test_full();
        bus.req = 4'b0001;
        for (int k = 4; k < SLOTS; k++) begin
            tick();
            checks++; if (bus.gnt_slot !== 4'(k)) begin errors++; $display("FAIL fill_slot%0d got %0d exp %0d", k, bus.gnt_slot, k); end
            tick();
        end
        bus.req = 4'b0010;
        checks++; if (bus.used_cnt !== 5'd10) begin errors++; $display("FAIL full_used_cnt got %0d exp 10", bus.used_cnt); end
        checks++; if (bus.full !== 1'b1) begin errors++; $display("FAIL full_flag got %b exp 1", bus.full); end
`ifdef BODY_SLOT_HWM_EN
        checks++; if (bus.hwm !== 5'd10) begin errors++; $display("FAIL full_hwm got %0d exp 10", bus.hwm); end
`endif
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++; if (bus.gnt !== 4'b0000) begin errors++; $display("FAIL full_nogrant%0d got %b exp 0000", k, bus.gnt); end
        end
        bus.free_vld  = 1'b1;
        bus.free_slot = 4'd7;
        tick();
        bus.free_vld = 1'b0;
        checks++; if (bus.full !== 1'b0) begin errors++; $display("FAIL free7_full got %b exp 0", bus.full); end
        checks++; if (bus.used_cnt !== 5'd9) begin errors++; $display("FAIL free7_used_cnt got %0d exp 9", bus.used_cnt); end
        checks++; if (bus.gnt !== 4'b0000) begin errors++; $display("FAIL free7_same_edge_gnt got %b exp 0000", bus.gnt); end
        tick();
        checks++; if (bus.gnt !== 4'b0010) begin errors++; $display("FAIL refill_gnt got %b exp 0010", bus.gnt); end
        checks++; if (bus.gnt_slot !== 4'd7) begin errors++; $display("FAIL refill_slot got %0d exp 7", bus.gnt_slot); end
        checks++; if (bus.full !== 1'b1) begin errors++; $display("FAIL refill_full got %b exp 1", bus.full); end
        bus.req = 4'b0000;
        tick();
    endtask

    task automatic test_illegal_free();
        bus.free_vld  = 1'b1;
        bus.free_slot = 4'd12;
        tick();
        checks++; if (bus.free_err !== 1'b1) begin errors++; $display("FAIL oor_free_err got %b exp 1", bus.free_err); end
        checks++; if (bus.used_cnt !== 5'd10) begin errors++; $display("FAIL oor_used_cnt got %0d exp 10", bus.used_cnt); end
        bus.free_vld = 1'b0;
        tick();
        checks++; if (bus.free_err !== 1'b0) begin errors++; $display("FAIL oor_err_pulse got %b exp 0", bus.free_err); end
        bus.free_vld  = 1'b1;
        bus.free_slot = 4'd3;
        tick();
        checks++; if (bus.free_err !== 1'b0) begin errors++; $display("FAIL free3_err got %b exp 0", bus.free_err); end
        checks++; if (bus.used_cnt !== 5'd9) begin errors++; $display("FAIL free3_used_cnt got %0d exp 9", bus.used_cnt); end
        tick();
        checks++; if (bus.free_err !== 1'b1) begin errors++; $display("FAIL dbl_free_err got %b exp 1", bus.free_err); end
        checks++; if (bus.used_cnt !== 5'd9) begin errors++; $display("FAIL dbl_used_cnt got %0d exp 9", bus.used_cnt); end
        bus.free_vld = 1'b0;
        tick();
        checks++; if (bus.free_err !== 1'b0) begin errors++; $display("FAIL dbl_err_pulse got %b exp 0", bus.free_err); end
    endtask

    task automatic test_grant_and_free();
        bus.req       = 4'b0100;
        bus.free_vld  = 1'b1;
        bus.free_slot = 4'd5;
        tick();
        checks++; if (bus.gnt !== 4'b0100) begin errors++; $display("FAIL gf_gnt got %b exp 0100", bus.gnt); end
        checks++; if (bus.gnt_slot !== 4'd3) begin errors++; $display("FAIL gf_slot got %0d exp 3", bus.gnt_slot); end
        checks++; if (bus.used_cnt !== 5'd9) begin errors++; $display("FAIL gf_used_cnt got %0d exp 9", bus.used_cnt); end
        checks++; if (bus.free_err !== 1'b0) begin errors++; $display("FAIL gf_free_err got %b exp 0", bus.free_err); end
        bus.req      = 4'b0000;
        bus.free_vld = 1'b0;
        tick();
        bus.req = 4'b1000;
        tick();
        checks++; if (bus.gnt !== 4'b1000) begin errors++; $display("FAIL gf_next_gnt got %b exp 1000", bus.gnt); end
        checks++; if (bus.gnt_slot !== 4'd5) begin errors++; $display("FAIL gf_next_slot got %0d exp 5", bus.gnt_slot); end
        checks++; if (bus.used_cnt !== 5'd10) begin errors++; $display("FAIL gf_next_used_cnt got %0d exp 10", bus.used_cnt); end
        bus.req = 4'b0000;
        tick();
    endtask

    task automatic test_reset_in_hold();
        do_reset();
        bus.req = 4'b0001;
        for (int k = 0; k < 5; k++) begin
            tick();
            tick();
        end
        tick();
        checks++; if (bus.gnt !== 4'b0001) begin errors++; $display("FAIL hold6_gnt got %b exp 0001", bus.gnt); end
        checks++; if (bus.used_cnt !== 5'd6) begin errors++; $display("FAIL hold6_used_cnt got %0d exp 6", bus.used_cnt); end
`ifdef BODY_SLOT_HWM_EN
        checks++; if (bus.hwm !== 5'd6) begin errors++; $display("FAIL hold6_hwm got %0d exp 6", bus.hwm); end
`else
        checks++; if (bus.hwm !== 5'd0) begin errors++; $display("FAIL hold6_hwm got %0d exp 0", bus.hwm); end
`endif
        bus.req = 4'b0000;
        rst     = 1'b1;
        #1;
        checks++; if (bus.gnt !== 4'b0000) begin errors++; $display("FAIL mid_rst_gnt got %b exp 0000", bus.gnt); end
        checks++; if (bus.used_cnt !== 5'd0) begin errors++; $display("FAIL mid_rst_used_cnt got %0d exp 0", bus.used_cnt); end
        checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL mid_rst_empty got %b exp 1", bus.empty); end
        checks++; if (bus.hwm !== 5'd0) begin errors++; $display("FAIL mid_rst_hwm got %0d exp 0", bus.hwm); end
        tick();
        rst     = 1'b0;
        bus.req = 4'b1111;
        tick();
        checks++; if (bus.gnt !== 4'b0001) begin errors++; $display("FAIL post_rst_gnt got %b exp 0001", bus.gnt); end
        checks++; if (bus.gnt_slot !== 4'd0) begin errors++; $display("FAIL post_rst_slot got %0d exp 0", bus.gnt_slot); end
        bus.req = 4'b0000;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    initial begin
        checks        = 0;
        errors        = 0;
        rst           = 1'b1;
        bus.req       = '0;
        bus.free_vld  = 1'b0;
        bus.free_slot = '0;
        test_reset();
        test_single_grant();
        test_round_robin();
        test_full();
        test_illegal_free();
        test_grant_and_free();
        test_reset_in_hold();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
